// File: rtl/q_channel_arbiter_pkg.sv
// Shared types and configuration for the Q/P channel round-robin arbiter.
// Configuration lives here so every file agrees on widths and the grant index type.
package q_arb_pkg;

  localparam int NUM_MST   = 4;
  localparam int AW        = 16;
  localparam int DW        = 32;
  localparam int MAX_OUTST = 4;
  localparam int IDX_W     = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef logic [IDX_W-1:0] grant_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  // Round-robin successor of a grant index, wrapping at NUM_MST.
  function automatic grant_idx_t next_ptr(grant_idx_t g);
    return (int'(g) == NUM_MST - 1) ? '0 : grant_idx_t'(int'(g) + 1);
  endfunction

endpackage

// File: rtl/q_channel_arbiter_if.sv
// Bundle of the per-master Q/P channels and the single downstream slave port.
// master = arbiter view (it masters the downstream port), slave = surrounding fabric view.
interface q_channel_arbiter_if;
  import q_arb_pkg::*;

  logic [NUM_MST-1:0]    m_qvalid;
  logic [NUM_MST-1:0]    m_qready;
  logic [NUM_MST-1:0]    m_qwrite;
  logic [NUM_MST*AW-1:0] m_qaddr;
  logic [NUM_MST*DW-1:0] m_qdata;
  logic                  s_qvalid;
  logic                  s_qready;
  logic                  s_qwrite;
  logic [AW-1:0]         s_qaddr;
  logic [DW-1:0]         s_qdata;
  logic                  s_pvalid;
  logic                  s_pready;
  logic [DW-1:0]         s_pdata;
  logic [NUM_MST-1:0]    m_pvalid;
  logic [NUM_MST-1:0]    m_pready;
  logic [DW-1:0]         m_pdata;
  logic                  err_orphan;

  modport master (
    input  m_qvalid, m_qwrite, m_qaddr, m_qdata, s_qready, s_pvalid, s_pdata, m_pready,
    output m_qready, s_qvalid, s_qwrite, s_qaddr, s_qdata, s_pready, m_pvalid, m_pdata,
           err_orphan
  );

  modport slave (
    output m_qvalid, m_qwrite, m_qaddr, m_qdata, s_qready, s_pvalid, s_pdata, m_pready,
    input  m_qready, s_qvalid, s_qwrite, s_qaddr, s_qdata, s_pready, m_pvalid, m_pdata,
           err_orphan
  );

endinterface

// File: rtl/q_channel_arbiter_order_fifo.sv
// Grant-order FIFO: remembers which master owns each outstanding request so
// in-order responses can be steered back. Pointers carry one wrap bit.
module q_order_fifo
  import q_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  grant_idx_t push_data,
  input  logic       pop,
  output grant_idx_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  grant_idx_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_q[PW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/q_channel_arbiter.sv
// Round-robin arbiter sharing one Q/P channel pair among NUM_MST masters:
// registers the winning request downstream and steers in-order responses back.
module q_channel_arbiter
  import q_arb_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  q_channel_arbiter_if.master bus
);

  state_t     state_q, state_d;
  grant_idx_t rr_ptr_q;
  grant_idx_t winner;
  grant_idx_t head;
  grant_idx_t idx;
  req_t       req_q;
  req_t       sel_req;
  logic       any_req;
  logic       can_capture;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       err_q;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    winner  = rr_ptr_q;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      idx = grant_idx_t'((int'(rr_ptr_q) + i) % NUM_MST);
      if (!any_req && bus.m_qvalid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (winner == grant_idx_t'(i)) begin
        sel_req = '{write: bus.m_qwrite[i],
                    addr:  bus.m_qaddr[i*AW +: AW],
                    data:  bus.m_qdata[i*DW +: DW]};
      end
    end
  end

  // Reset gates the accept so no master sees M_QREADY while the block is held in reset.
  assign can_capture = rst_n && ((state_q == IDLE) || bus.s_qready) && !fifo_full && any_req;
  assign bus.m_qready = can_capture ? (NUM_MST'(1) << winner) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (can_capture) state_d = BUSY;
      BUSY:    if (bus.s_qready && !can_capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (can_capture) begin
        rr_ptr_q <= next_ptr(winner);
        req_q    <= sel_req;
      end
      if (bus.s_pvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.s_qvalid   = (state_q == BUSY);
  assign bus.s_qwrite   = req_q.write;
  assign bus.s_qaddr    = req_q.addr;
  assign bus.s_qdata    = req_q.data;
  assign bus.err_orphan = err_q;

  // Responses return in grant order, so the FIFO head names the owning master.
  always_comb begin
    bus.m_pvalid = '0;
    bus.s_pready = 1'b0;
    if (!fifo_empty) begin
      bus.m_pvalid[head] = bus.s_pvalid;
      bus.s_pready       = bus.m_pready[head];
    end
  end

  assign bus.m_pdata = bus.s_pdata;
  assign pop         = bus.s_pvalid && bus.s_pready;

  q_order_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (can_capture),
    .push_data (winner),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_q_channel_arbiter.sv
// Directed bench for q_channel_arbiter: a queue-based reference model is compared
// against every output on each falling edge, plus literal checks per scenario.
module tb_q_channel_arbiter;
  import q_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  q_channel_arbiter_if bus();

  q_channel_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: outstanding grant order, output register, RR pointer.
  int            order_q[$];
  int            grant_log[$];
  bit            m_busy;
  bit            m_err;
  int            m_rr;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(negedge clk) begin
    int                 w, h, c;
    bit                 cap, any, was_empty;
    logic [NUM_MST-1:0] exp_qready, exp_pvalid;
    logic               exp_pready;
    if (!rst_n) begin
      check("rst_m_qready", 64'(bus.m_qready), 64'(0));
      check("rst_s_qvalid", 64'(bus.s_qvalid), 64'(0));
      check("rst_s_qwrite", 64'(bus.s_qwrite), 64'(0));
      check("rst_s_qaddr", 64'(bus.s_qaddr), 64'(0));
      check("rst_s_qdata", 64'(bus.s_qdata), 64'(0));
      check("rst_m_pvalid", 64'(bus.m_pvalid), 64'(0));
      check("rst_s_pready", 64'(bus.s_pready), 64'(0));
      check("rst_err", 64'(bus.err_orphan), 64'(0));
      order_q.delete();
      m_busy = 0; m_err = 0; m_rr = 0;
      m_write = 0; m_addr = '0; m_data = '0;
    end else begin
      any = 0; w = 0;
      for (int k = 0; k < NUM_MST; k++) begin
        c = (m_rr + k) % NUM_MST;
        if (!any && bus.m_qvalid[c[IDX_W-1:0]]) begin
          any = 1;
          w   = c;
        end
      end
      cap = any && (!m_busy || bus.s_qready) && (order_q.size() < MAX_OUTST);
      exp_qready = '0;
      if (cap) exp_qready[w[IDX_W-1:0]] = 1'b1;
      exp_pvalid = '0;
      exp_pready = 1'b0;
      was_empty  = (order_q.size() == 0);
      if (!was_empty) begin
        h = order_q[0];
        exp_pvalid[h[IDX_W-1:0]] = bus.s_pvalid;
        exp_pready = bus.m_pready[h[IDX_W-1:0]];
      end
      check("m_qready", 64'(bus.m_qready), 64'(exp_qready));
      check("s_qvalid", 64'(bus.s_qvalid), 64'(m_busy));
      check("s_qwrite", 64'(bus.s_qwrite), 64'(m_write));
      check("s_qaddr", 64'(bus.s_qaddr), 64'(m_addr));
      check("s_qdata", 64'(bus.s_qdata), 64'(m_data));
      check("m_pvalid", 64'(bus.m_pvalid), 64'(exp_pvalid));
      check("s_pready", 64'(bus.s_pready), 64'(exp_pready));
      check("m_pdata", 64'(bus.m_pdata), 64'(bus.s_pdata));
      check("err_orphan", 64'(bus.err_orphan), 64'(m_err));
      if (bus.m_qready != '0) grant_log.push_back($clog2(bus.m_qready));
      if (!was_empty && bus.s_pvalid && exp_pready) void'(order_q.pop_front());
      if (was_empty && bus.s_pvalid) m_err = 1;
      if (cap) begin
        order_q.push_back(w);
        m_busy  = 1;
        m_rr    = (w + 1) % NUM_MST;
        m_write = bus.m_qwrite[w[IDX_W-1:0]];
        m_addr  = AW'(bus.m_qaddr >> (w * AW));
        m_data  = DW'(bus.m_qdata >> (w * DW));
      end else if (m_busy && bus.s_qready) begin
        m_busy = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n        = 1'b0;
    bus.m_qvalid = '0;
    bus.s_qready = 1'b0;
    bus.s_pvalid = 1'b0;
    bus.s_pdata  = '0;
    bus.m_pready = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      bus.m_qwrite[i]          = i[0];
      bus.m_qaddr[i*AW +: AW]  = AW'(16'hA000 + i);
      bus.m_qdata[i*DW +: DW]  = DW'(32'hD000_0000 + i * 32'h11);
    end
    repeat (3) next_cycle();
    rst_n = 1'b1;
    at_neg();
    check("init_s_qvalid", 64'(bus.s_qvalid), 64'(0));
    check("init_m_qready", 64'(bus.m_qready), 64'(0));
    check("init_err", 64'(bus.err_orphan), 64'(0));

    // Round robin, one grant per cycle, responses keep the FIFO from filling.
    next_cycle();
    grant_log.delete();
    bus.s_qready = 1'b1;
    bus.m_pready = '1;
    bus.m_qvalid = '1;
    next_cycle();
    bus.s_pvalid = 1'b1;
    bus.s_pdata  = 32'h5000_0000;
    at_neg();
    check("rr_s_qaddr0", 64'(bus.s_qaddr), 64'(16'hA000));
    check("rr_m_pvalid0", 64'(bus.m_pvalid), 64'(4'b0001));
    repeat (3) begin
      next_cycle();
      bus.s_pdata = bus.s_pdata + 32'd1;
    end
    next_cycle();
    bus.m_qvalid = '0;
    next_cycle();
    bus.s_pvalid = 1'b0;
    check("rr_grant_count", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("rr_grant_order", 64'(grant_log[i]), 64'(exp_rr[i]));

    // Backpressure: held request stays stable, resume captures in the same cycle.
    next_cycle();
    bus.s_qready = 1'b0;
    bus.m_qvalid = 4'b0110;
    at_neg();
    check("bp_first_grant", 64'(bus.m_qready), 64'(4'b0010));
    repeat (5) begin
      next_cycle();
      at_neg();
      check("bp_no_qready", 64'(bus.m_qready), 64'(0));
      check("bp_hold_valid", 64'(bus.s_qvalid), 64'(1));
      check("bp_hold_addr", 64'(bus.s_qaddr), 64'(16'hA001));
    end
    next_cycle();
    bus.s_qready = 1'b1;
    at_neg();
    check("bp_resume_grant", 64'(bus.m_qready), 64'(4'b0100));
    next_cycle();
    bus.m_qvalid = '0;
    bus.s_pvalid = 1'b1;
    at_neg();
    check("bp_resp_m1", 64'(bus.m_pvalid), 64'(4'b0010));
    next_cycle();
    at_neg();
    check("bp_resp_m2", 64'(bus.m_pvalid), 64'(4'b0100));
    next_cycle();
    bus.s_pvalid = 1'b0;

    // Outstanding limit: four captures, a pop only frees a slot for the next cycle.
    next_cycle();
    grant_log.delete();
    bus.m_qvalid = '1;
    repeat (3) next_cycle();
    next_cycle();
    at_neg();
    check("os_full_block", 64'(bus.m_qready), 64'(0));
    check("os_capture_count", 64'(grant_log.size()), 64'(4));
    next_cycle();
    bus.s_pvalid = 1'b1;
    at_neg();
    check("os_pop_same_cycle", 64'(bus.m_qready), 64'(0));
    check("os_pop_head", 64'(bus.m_pvalid), 64'(4'b1000));
    next_cycle();
    bus.s_pvalid = 1'b0;
    at_neg();
    check("os_fifth_capture", 64'(bus.m_qready), 64'(4'b1000));
    next_cycle();
    bus.m_qvalid = '0;
    bus.s_pvalid = 1'b1;
    repeat (3) next_cycle();
    next_cycle();
    bus.s_pvalid = 1'b0;

    // Steering: grants to 2, 0, 3 and a stalled response for master 0.
    next_cycle();
    bus.m_qvalid = 4'b0100;
    next_cycle();
    bus.m_qvalid = 4'b0001;
    next_cycle();
    bus.m_qvalid = 4'b1000;
    next_cycle();
    bus.m_qvalid = '0;
    bus.s_pvalid = 1'b1;
    bus.s_pdata  = 32'hCAFE_0002;
    at_neg();
    check("st_resp_m2", 64'(bus.m_pvalid), 64'(4'b0100));
    check("st_resp_data", 64'(bus.m_pdata), 64'(32'hCAFE_0002));
    next_cycle();
    bus.m_pready = 4'b1110;
    at_neg();
    check("st_stall_pvalid", 64'(bus.m_pvalid), 64'(4'b0001));
    check("st_stall_pready", 64'(bus.s_pready), 64'(0));
    next_cycle();
    at_neg();
    check("st_stall_pready2", 64'(bus.s_pready), 64'(0));
    next_cycle();
    bus.m_pready = '1;
    at_neg();
    check("st_resp_m0", 64'(bus.m_pvalid), 64'(4'b0001));
    check("st_resp_m0_ready", 64'(bus.s_pready), 64'(1));
    next_cycle();
    at_neg();
    check("st_resp_m3", 64'(bus.m_pvalid), 64'(4'b1000));
    next_cycle();
    bus.s_pvalid = 1'b0;

    // Orphan response with nothing outstanding.
    next_cycle();
    bus.s_pvalid = 1'b1;
    at_neg();
    check("orph_pready", 64'(bus.s_pready), 64'(0));
    check("orph_pvalid", 64'(bus.m_pvalid), 64'(0));
    check("orph_err_same", 64'(bus.err_orphan), 64'(0));
    next_cycle();
    bus.s_pvalid = 1'b0;
    at_neg();
    check("orph_err_set", 64'(bus.err_orphan), 64'(1));
    repeat (3) next_cycle();
    at_neg();
    check("orph_err_sticky", 64'(bus.err_orphan), 64'(1));

    // Reset in the middle of traffic, then lowest requester wins first.
    next_cycle();
    bus.m_qvalid = '1;
    bus.s_qready = 1'b0;
    at_neg();
    check("mid_grant", 64'(bus.m_qready), 64'(4'b0001));
    next_cycle();
    bus.s_pvalid = 1'b1;
    rst_n = 1'b0;
    at_neg();
    check("mid_rst_qvalid", 64'(bus.s_qvalid), 64'(0));
    check("mid_rst_qready", 64'(bus.m_qready), 64'(0));
    check("mid_rst_pvalid", 64'(bus.m_pvalid), 64'(0));
    check("mid_rst_err", 64'(bus.err_orphan), 64'(0));
    next_cycle();
    bus.s_pvalid = 1'b0;
    bus.m_qvalid = 4'b1010;
    next_cycle();
    rst_n = 1'b1;
    at_neg();
    check("post_rst_grant", 64'(bus.m_qready), 64'(4'b0010));

    repeat (3) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
